rr_arbiter_2x1: RTL and testbench

RR_ARBITER_2X1 -- requirements
Module: rr_arbiter_2x1

---
 rtl/rr_arbiter_2x1.sv | 177 +++++++++++++++++
 tb/tb_rr_arbiter_2x1.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_2x1.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2x1
//
// Two-requester round-robin arbiter that drives a shared registered data path.
// A grant lasts at most MAX_BEATS beats. It ends early if the granted
// requester drops its request. When both sides ask at once from IDLE, the
// side that was not granted most recently wins. When a grant ends and the
// other side is waiting, the arbiter hands over directly, with no idle cycle
// in between.
//
// Parameters
//   WIDTH      data width of d0, d1 and y
//   MAX_BEATS  maximum consecutive beats per grant (legal range 1..15)
//
// Ports
//   clk      in   1      clock; all state updates on the rising edge
//   rst_n    in   1      asynchronous active-low reset
//   req0     in   1      requester 0 request, held high while it has data
//   d0       in   WIDTH  requester 0 data
//   req1     in   1      requester 1 request
//   d1       in   WIDTH  requester 1 data
//   gnt0     out  1      grant to requester 0 (decoded from the state register)
//   gnt1     out  1      grant to requester 1 (decoded from the state register)
//   sel      out  1      registered mux select, 0 = d0 path, 1 = d1 path
//   y        out  WIDTH  registered shared-path output
//   y_valid  out  1      high for one cycle per transferred beat
// ---------------------------------------------------------------------------
module rr_arbiter_2x1 #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // The beat counter is 4 bits wide, which covers MAX_BEATS up to 15.
    localparam logic [3:0] MAX_CNT = 4'(MAX_BEATS);

    state_t           state;
    state_t           state_nxt;
    logic             last;
    logic             last_nxt;
    logic             sel_nxt;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic [3:0]       cnt_inc;
    logic [WIDTH-1:0] y_nxt;
    logic             y_valid_nxt;
    logic             own_req;
    logic             other_req;
    logic             beat;
    logic             grant_end;
    logic             enter_g0;
    logic             enter_g1;

    // The grants come straight from the state register. Because the state can
    // only be one value at a time, the two grants can never be high together.
    assign gnt0 = (state == GNT0);
    assign gnt1 = (state == GNT1);

    // Next-state and datapath logic.
    // A beat transfers the granted side's data into y and advances the beat
    // counter. The grant ends on the edge where the count reaches MAX_BEATS,
    // or on the edge where the granted request is sampled low. Entering a
    // grant always clears the counter, records the side in 'last' and updates
    // sel. This also covers re-entering the same grant after MAX_BEATS.
    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        sel_nxt     = sel;
        cnt_nxt     = cnt;
        y_nxt       = y;
        y_valid_nxt = 1'b0;
        enter_g0    = 1'b0;
        enter_g1    = 1'b0;

        own_req   = (state == GNT1) ? req1 : req0;
        other_req = (state == GNT1) ? req0 : req1;
        beat      = ((state == GNT0) && req0) || ((state == GNT1) && req1);
        cnt_inc   = cnt + 4'd1;
        grant_end = (state != IDLE) && (!own_req || (cnt_inc == MAX_CNT));

        if (beat) begin
            y_nxt       = (state == GNT1) ? d1 : d0;
            y_valid_nxt = 1'b1;
            cnt_nxt     = cnt_inc;
        end

        case (state)
            IDLE: begin
                if (req0 && (!req1 || last)) begin
                    enter_g0 = 1'b1;
                end else if (req1) begin
                    enter_g1 = 1'b1;
                end
            end
            GNT0: begin
                if (grant_end) begin
                    if (req1) begin
                        enter_g1 = 1'b1;
                    end else if (req0) begin
                        enter_g0 = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GNT1: begin
                if (grant_end) begin
                    if (req0) begin
                        enter_g0 = 1'b1;
                    end else if (req1) begin
                        enter_g1 = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (enter_g0) begin
            state_nxt = GNT0;
            last_nxt  = 1'b0;
            sel_nxt   = 1'b0;
            cnt_nxt   = 4'd0;
        end else if (enter_g1) begin
            state_nxt = GNT1;
            last_nxt  = 1'b1;
            sel_nxt   = 1'b1;
            cnt_nxt   = 4'd0;
        end

        if (other_req && 1'b0) begin
            state_nxt = IDLE;
        end
    end

    // State and output registers.
    // Reset sets 'last' to 1, so requester 0 wins the first tie after reset.
    // Asserting reset in the middle of a grant aborts it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= 1'b1;
            sel     <= 1'b0;
            cnt     <= 4'd0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            sel     <= sel_nxt;
            cnt     <= cnt_nxt;
            y       <= y_nxt;
            y_valid <= y_valid_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_2x1.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_2x1
//
// Directed testbench for rr_arbiter_2x1. It runs two instances that share
// their inputs:
//   dut   WIDTH=8, MAX_BEATS=4
//   dut1  WIDTH=8, MAX_BEATS=1
// Most checks use a table of {inputs, expected outputs} vectors. Each vector
// is applied before a rising edge and its outputs are checked 1 time unit
// after that edge. Hand-written sequences cover the handover, the
// asynchronous reset in the middle of a grant, and alternation with
// MAX_BEATS=1.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_2x1;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic       req1;
    logic [7:0] d0;
    logic [7:0] d1;

    logic       gnt0;
    logic       gnt1;
    logic       sel;
    logic [7:0] y;
    logic       y_valid;

    logic       gnt0_b;
    logic       gnt1_b;
    logic       sel_b;
    logic [7:0] y_b;
    logic       y_valid_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic       req0;
        logic [7:0] d0;
        logic       req1;
        logic [7:0] d1;
        logic       e_gnt0;
        logic       e_gnt1;
        logic       e_sel;
        logic [7:0] e_y;
        logic       e_yv;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter_2x1 #(.WIDTH(8), .MAX_BEATS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .d0      (d0),
        .req1    (req1),
        .d1      (d1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
    );

    rr_arbiter_2x1 #(.WIDTH(8), .MAX_BEATS(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .d0      (d0),
        .req1    (req1),
        .d1      (d1),
        .gnt0    (gnt0_b),
        .gnt1    (gnt1_b),
        .sel     (sel_b),
        .y       (y_b),
        .y_valid (y_valid_b)
    );

    // Free-running clock with a period of 10 time units.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives every DUT input for one cycle. Blocking assignments are used so
    // the values are stable well before the next rising edge.
    task automatic applyStimulus(input logic r, input logic q0, input logic [7:0] a,
                                 input logic q1, input logic [7:0] b);
        rst_n = r;
        req0  = q0;
        d0    = a;
        req1  = q1;
        d1    = b;
    endtask

    // Waits for the next rising edge, then lets the outputs settle for 1 time
    // unit before they are checked.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares the outputs of one instance against the expected values as a
    // single packed word: {gnt0, gnt1, sel, y, y_valid}.
    // which = 0 selects dut, which = 1 selects dut1.
    task automatic checkOutput(input string name, input bit which,
                               input logic eg0, input logic eg1, input logic es,
                               input logic [7:0] ey, input logic eyv);
        logic [11:0] act;
        logic [11:0] exp;
        act = which ? {gnt0_b, gnt1_b, sel_b, y_b, y_valid_b}
                    : {gnt0, gnt1, sel, y, y_valid};
        exp = {eg0, eg1, es, ey, eyv};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got g0=%b g1=%b sel=%b y=%h yv=%b, want g0=%b g1=%b sel=%b y=%h yv=%b",
                     name, act[11], act[10], act[9], act[8:1], act[0],
                     exp[11], exp[10], exp[9], exp[8:1], exp[0]);
        end
    endtask

    initial begin
        // Vector table. Columns:
        //   inputs:   rst_n, req0, d0, req1, d1
        //   expected: gnt0, gnt1, sel, y, y_valid
        // Single requester with re-grant after four beats. req1 pulses on row 3
        // while requester 0 holds the grant and must not disturb it.
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'h22, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h44, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0});
        // Tie after reset: GNT0 for four beats, then GNT1 for four beats,
        // then GNT0 again, with no IDLE cycle in between.
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'hA1, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 8'hA1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'hA2, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 8'hA2, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'hA3, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 8'hA3, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'hA4, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b1, 8'hA4, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'hA9, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 8'hB1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'hA9, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'hA9, 1'b1, 8'hB3, 1'b0, 1'b1, 1'b1, 8'hB3, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'hA9, 1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 8'hB4, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'hA5, 1'b1, 8'hB9, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1});
        // Early release: two beats from requester 1, then IDLE. sel stays 1
        // and y holds the last transferred value.
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 8'hC1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 8'hC1, 1'b0, 1'b1, 1'b1, 8'hC1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 8'hC2, 1'b0, 1'b1, 1'b1, 8'hC2, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hC2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 8'hC4, 1'b0, 1'b0, 1'b1, 8'hC2, 1'b0});

        // Asynchronous reset at power-up, checked before any clock edge.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async_start", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].req0, vecs[i].d0, vecs[i].req1, vecs[i].d1);
            step();
            checkOutput($sformatf("vec%0d", i), 1'b0, vecs[i].e_gnt0, vecs[i].e_gnt1,
                        vecs[i].e_sel, vecs[i].e_y, vecs[i].e_yv);
        end

        // Handover. Starting from IDLE with last = 1, a tie goes to GNT0.
        // req0 then drops after one beat while req1 is high, so the arbiter
        // must go straight to GNT1.
        applyStimulus(1'b1, 1'b1, 8'hD1, 1'b1, 8'hE0);
        step();
        checkOutput("handover_gnt0", 1'b0, 1'b1, 1'b0, 1'b0, 8'hC2, 1'b0);
        step();
        checkOutput("handover_beat1", 1'b0, 1'b1, 1'b0, 1'b0, 8'hD1, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'hD2, 1'b1, 8'hE1);
        step();
        checkOutput("handover_gnt1", 1'b0, 1'b0, 1'b1, 1'b1, 8'hD1, 1'b0);
        step();
        checkOutput("handover_d1_beat", 1'b0, 1'b0, 1'b1, 1'b1, 8'hE1, 1'b1);

        // Reset in the middle of a grant: pulse rst_n low right after GNT1's
        // second beat. All outputs must clear without a clock edge. After
        // release with both requests high, requester 0 must win.
        applyStimulus(1'b1, 1'b1, 8'hD3, 1'b1, 8'hE2);
        step();
        checkOutput("midgrant_beat2", 1'b0, 1'b0, 1'b1, 1'b1, 8'hE2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midgrant_async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        rst_n = 1'b1;
        step();
        checkOutput("after_reset_gnt0", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // MAX_BEATS=1 instance with both requests held: grants alternate
        // every cycle and y_valid stays high once the first beat has happened.
        applyStimulus(1'b0, 1'b1, 8'h0F, 1'b1, 8'hF0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("mb1_first_gnt0", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int k = 2; k <= 7; k++) begin
            step();
            if (k % 2 == 0) begin
                checkOutput($sformatf("mb1_step%0d", k), 1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b1);
            end else begin
                checkOutput($sformatf("mb1_step%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 8'hF0, 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
